// File: rtl/vga_frame_monitor.sv
// Receive-side VGA checker: measures line/frame timing, active pixel count and a
// rotating colour checksum per frame, with sticky timing-error flags and lock status.
module vga_frame_monitor #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vga_clk,
    input  logic        vga_blank,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic [1:0]  vga_red,
    input  logic [1:0]  vga_green,
    input  logic [1:0]  vga_blue,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic [11:0] line_len,
    output logic [10:0] frame_lines,
    output logic [19:0] active_pixels,
    output logic [15:0] checksum,
    output logic        hlen_err,
    output logic        vlen_err,
    output logic        act_err,
    output logic        locked
);
    localparam logic [11:0] H_EXP = 12'(H_TOTAL);
    localparam logic [10:0] V_EXP = 11'(V_TOTAL);
    localparam logic [19:0] A_EXP = 20'(H_ACTIVE * V_ACTIVE);

    logic        vga_clk_d, hs_d, vs_d;
    logic [11:0] h_cnt;
    logic [10:0] v_cnt;
    logic [19:0] a_cnt;
    logic [15:0] csum;
    logic        h_seen, v_seen, frame_bad;

    logic        tick, hfall, vfall, active, h_bad, v_bad, a_bad;
    logic [5:0]  rgb;
    logic [15:0] csum_next;

    assign tick      = vga_clk & ~vga_clk_d;
    assign hfall     = hs_d & ~vga_hsync;
    assign vfall     = vs_d & ~vga_vsync;
    assign active    = ~vga_blank;
    assign rgb       = {vga_red, vga_green, vga_blue};
    // h_bad is only meaningful on a measured line edge; the others only at frame close
    assign h_bad     = hfall & h_seen & (h_cnt != H_EXP);
    assign v_bad     = (v_cnt != V_EXP);
    assign a_bad     = (a_cnt != A_EXP);
    assign csum_next = {csum[14:0], csum[15]} ^ {10'b0, rgb};

    always_ff @(posedge clock) begin
        if (reset) begin
            vga_clk_d     <= 1'b0;
            hs_d          <= 1'b1;
            vs_d          <= 1'b1;
            h_cnt         <= '0;
            v_cnt         <= '0;
            a_cnt         <= '0;
            csum          <= '0;
            h_seen        <= 1'b0;
            v_seen        <= 1'b0;
            frame_bad     <= 1'b0;
            frame_done    <= 1'b0;
            frame_count   <= '0;
            line_len      <= '0;
            frame_lines   <= '0;
            active_pixels <= '0;
            checksum      <= '0;
            hlen_err      <= 1'b0;
            vlen_err      <= 1'b0;
            act_err       <= 1'b0;
            locked        <= 1'b0;
        end else begin
            vga_clk_d  <= vga_clk;
            frame_done <= 1'b0;
            if (tick) begin
                hs_d <= vga_hsync;
                vs_d <= vga_vsync;

                if (hfall) begin
                    if (h_seen) line_len <= h_cnt;
                    if (h_bad)  hlen_err <= 1'b1;
                    h_cnt  <= 12'd1;
                    h_seen <= 1'b1;
                end else if (h_cnt != '1) begin
                    h_cnt <= h_cnt + 12'd1;
                end

                // A coincident line edge and pixel belong to the frame being opened
                if (vfall) begin
                    v_seen    <= 1'b1;
                    v_cnt     <= hfall ? 11'd1 : 11'd0;
                    a_cnt     <= active ? 20'd1 : 20'd0;
                    csum      <= active ? {10'b0, rgb} : 16'd0;
                    frame_bad <= 1'b0;
                    if (v_seen) begin
                        frame_lines   <= v_cnt;
                        active_pixels <= a_cnt;
                        checksum      <= csum;
                        frame_done    <= 1'b1;
                        frame_count   <= frame_count + 16'd1;
                        if (v_bad) vlen_err <= 1'b1;
                        if (a_bad) act_err  <= 1'b1;
                        locked <= ~(frame_bad | h_bad | v_bad | a_bad);
                    end
                end else begin
                    if (hfall && v_cnt != '1) v_cnt <= v_cnt + 11'd1;
                    if (active) begin
                        if (a_cnt != '1) a_cnt <= a_cnt + 20'd1;
                        csum <= csum_next;
                    end
                    if (h_bad) frame_bad <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench for vga_frame_monitor: a frame-level generator pushes expected
// per-frame results; a monitor pops and compares on every frame_done pulse.
module tb_vga_frame_monitor;
    localparam int HT = 20;
    localparam int VT = 10;
    localparam int HA = 12;
    localparam int VA = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        vga_clk = 1'b0, vga_blank = 1'b1, vga_hsync = 1'b1, vga_vsync = 1'b1;
    logic [1:0]  vga_red = '0, vga_green = '0, vga_blue = '0;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [11:0] line_len;
    logic [10:0] frame_lines;
    logic [19:0] active_pixels;
    logic [15:0] checksum;
    logic        hlen_err, vlen_err, act_err, locked;

    vga_frame_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
        .clock(clock), .reset(reset), .vga_clk(vga_clk), .vga_blank(vga_blank),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_red(vga_red),
        .vga_green(vga_green), .vga_blue(vga_blue), .frame_done(frame_done),
        .frame_count(frame_count), .line_len(line_len), .frame_lines(frame_lines),
        .active_pixels(active_pixels), .checksum(checksum), .hlen_err(hlen_err),
        .vlen_err(vlen_err), .act_err(act_err), .locked(locked)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] count;
        logic [11:0] line_len;
        logic [10:0] lines;
        logic [19:0] act;
        logic [15:0] csum;
        logic        hlen, vlen, aerr, locked;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       pend, last_exp, mon_e;
    bit         pend_v;
    logic [5:0] pix_q[$];
    int         cur_last_len;
    bit         cur_hbad;
    bit         st_h, st_v, st_a;
    int         exp_count;
    int         total = 0;
    int         bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cmp_outputs(string tag, exp_t e);
        chk({tag, ".frame_count"},   32'(frame_count),   32'(e.count));
        chk({tag, ".line_len"},      32'(line_len),      32'(e.line_len));
        chk({tag, ".frame_lines"},   32'(frame_lines),   32'(e.lines));
        chk({tag, ".active_pixels"}, 32'(active_pixels), 32'(e.act));
        chk({tag, ".checksum"},      32'(checksum),      32'(e.csum));
        chk({tag, ".hlen_err"},      32'(hlen_err),      32'(e.hlen));
        chk({tag, ".vlen_err"},      32'(vlen_err),      32'(e.vlen));
        chk({tag, ".act_err"},       32'(act_err),       32'(e.aerr));
        chk({tag, ".locked"},        32'(locked),        32'(e.locked));
    endtask

    function automatic logic [15:0] rotl(logic [15:0] v, int k);
        return (k == 0) ? v : ((v << k) | (v >> (16 - k)));
    endfunction

    // One pixel-clock period of 2..4 system clocks with the given pin state
    task automatic do_tick(bit blank, bit hs, bit vs, logic [5:0] rgb);
        @(negedge clock);
        vga_blank = blank; vga_hsync = hs; vga_vsync = vs;
        {vga_red, vga_green, vga_blue} = rgb;
        vga_clk = 1'b1;
        repeat ($urandom_range(0, 1)) @(negedge clock);
        @(negedge clock);
        vga_clk = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clock);
    endtask

    // Line: hsync low ticks 0-1, active pixels from tick 4; vsync low on frame lines 0-1
    task automatic emit_line(int li, int len, int act, int cmode);
        bit         on;
        logic [5:0] c;
        for (int t = 0; t < len; t++) begin
            on = (t >= 4) && (t < 4 + act);
            c  = 6'h0;
            if (on) begin
                case (cmode)
                    1:       c = (pix_q.size() == 0) ? 6'h3F : 6'h00;
                    2:       c = 6'($urandom);
                    default: c = 6'h0;
                endcase
                pix_q.push_back(c);
            end
            do_tick(!on, t >= 2, li >= 2, c);
        end
        if (len != HT) cur_hbad = 1'b1;
        cur_last_len = len;
    endtask

    task automatic send_frame(int nl, int emit, int bad_li, int bad_len, int act_lines, int cmode);
        int          n;
        logic [15:0] cs;
        if (pend_v) begin
            exp_count++;
            pend.count = 16'(exp_count);
            sb_q.push_back(pend);
            last_exp = pend;
            pend_v = 1'b0;
        end
        pix_q.delete();
        cur_hbad = 1'b0;
        for (int li = 0; li < emit; li++)
            emit_line(li, (li == bad_li) ? bad_len : HT,
                      (li >= 2 && li < 2 + act_lines) ? HA : 0, cmode);
        if (emit == nl) begin
            n  = pix_q.size();
            cs = '0;
            for (int i = 0; i < n; i++) cs ^= rotl(16'(pix_q[i]), (n - 1 - i) % 16);
            st_h |= cur_hbad;
            st_v |= (nl != VT);
            st_a |= (n != HA * VA);
            pend.count    = '0;
            pend.line_len = 12'(cur_last_len);
            pend.lines    = 11'(nl);
            pend.act      = 20'(n);
            pend.csum     = cs;
            pend.hlen     = st_h;
            pend.vlen     = st_v;
            pend.aerr     = st_a;
            pend.locked   = !cur_hbad && (nl == VT) && (n == HA * VA);
            pend_v = 1'b1;
        end
    endtask

    always @(negedge clock) begin
        if (!reset && frame_done) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame_done actual=1 required=0 count=%0d", frame_count);
            end else begin
                mon_e = sb_q.pop_front();
                cmp_outputs("frame", mon_e);
            end
        end
    end

    initial begin
        exp_t zero;
        zero = '{count: '0, line_len: '0, lines: '0, act: '0, csum: '0,
                 hlen: 1'b0, vlen: 1'b0, aerr: 1'b0, locked: 1'b0};
        pend_v = 1'b0; st_h = 1'b0; st_v = 1'b0; st_a = 1'b0; exp_count = 0;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        cmp_outputs("reset", zero);
        chk("reset.frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;

        send_frame(VT, VT, -1, 0, VA, 0);          // ideal, colour 0
        send_frame(VT, VT, -1, 0, VA, 1);          // first pixel 0x3F
        send_frame(VT, VT, -1, 0, VA, 2);          // random colours
        send_frame(VT, VT, 3, HT - 1, VA, 2);      // one short line
        send_frame(VT, VT, -1, 0, VA, 0);          // clean again: relock
        send_frame(VT - 1, VT - 1, -1, 0, VA - 1, 2); // short frame, short active
        send_frame(VT, VT, -1, 0, VA, 2);          // clean
        send_frame(VT, 3, -1, 0, VA, 0);           // partial frame, then stall

        @(negedge clock);
        vga_clk = 1'b1;
        repeat (2000) @(negedge clock);
        cmp_outputs("hold", last_exp);
        vga_clk = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        cmp_outputs("midreset", zero);
        sb_q.delete();
        pend_v = 1'b0; st_h = 1'b0; st_v = 1'b0; st_a = 1'b0; exp_count = 0;

        for (int li = 3; li < VT; li++)
            emit_line(li, HT, (li >= 2 && li < 2 + VA) ? HA : 0, 0);
        send_frame(VT, VT, -1, 0, VA, 2);          // opened by first vsync fall: no done
        send_frame(VT, VT, -1, 0, VA, 2);          // closes previous: count 1
        send_frame(VT, VT, -1, 0, VA, 1);
        repeat (10) @(negedge clock);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        chk("final.frame_count", 32'(frame_count), 32'(exp_count));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_frame_monitor.md
Name: vga_frame_monitor

Overview:
- Receive-side checker for the VGA pin bundle driven by the connect4 display design: VGA clock, blank, hsync, vsync, and 2-bit R/G/B.
- Samples that bundle in the system clock domain and measures line and frame timing.
- Counts active pixels and computes a per-frame colour checksum.
- Raises sticky timing-error flags and a locked indication, so benches and on-chip debug can check display output without dumping waveforms.

Parameters:
H_TOTAL, 800, expected pixel ticks per line (hsync fall to hsync fall)
V_TOTAL, 525, expected lines per frame (vsync fall to vsync fall)
H_ACTIVE, 640, expected active pixels per line
V_ACTIVE, 480, expected active lines per frame

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high
vga_clk  input  1  pixel clock from the display design, synchronous to clock, period >= 2 clock cycles
vga_blank  input  1  1 = blanking interval, 0 = active pixel
vga_hsync  input  1  horizontal sync, active-low
vga_vsync  input  1  vertical sync, active-low
vga_red  input  2  red
vga_green  input  2  green
vga_blue  input  2  blue
frame_done  output  1  one-cycle pulse when a frame closes
frame_count  output  16  frames closed since reset, wraps 0xFFFF->0
line_len  output  12  last measured line length in pixel ticks
frame_lines  output  11  lines in last closed frame
active_pixels  output  20  active pixels in last closed frame
checksum  output  16  colour checksum of last closed frame
hlen_err  output  1  sticky: some line length != H_TOTAL
vlen_err  output  1  sticky: some frame_lines != V_TOTAL
act_err  output  1  sticky: some active_pixels != H_ACTIVE*V_ACTIVE
locked  output  1  last closed frame had no line, frame or active-count error

Behaviour:
- Reset:
  - All outputs 0.
  - Internal vga_clk_d, hs_d and vs_d are set to 0, 1 and 1 respectively.
  - Counters are cleared; h_seen, v_seen and frame_bad are cleared.
  - Reset mid-frame discards the partial frame.
- Tick:
  - A tick is a clock cycle with vga_clk=1 and vga_clk_d=0.
  - All sampling, hs_d/vs_d updates and counting happen only on ticks.
  - With no ticks, all state holds.
- Line (tick where hs_d=1 and vga_hsync=0):
  - If h_seen: line_len <= h_cnt. If h_cnt != H_TOTAL, set hlen_err and frame_bad.
  - Always: h_cnt <= 1, h_seen <= 1, v_cnt <= v_cnt+1 (saturate 2047).
  - Other ticks: h_cnt <= h_cnt+1, saturating at 4095.
- Active pixel (tick with vga_blank=0):
  - a_cnt <= a_cnt+1, saturating at 2^20-1.
  - csum <= rotl1(csum) ^ {10'b0, red, green, blue}.
  - Blanked ticks leave a_cnt and csum unchanged.
- Frame close (tick where vs_d=1 and vga_vsync=0):
  - If v_seen, the following all take effect in the next cycle:
    - frame_lines <= v_cnt; active_pixels <= a_cnt; checksum <= csum.
    - frame_done pulses for exactly 1 cycle; frame_count increments.
    - If v_cnt != V_TOTAL, set vlen_err. If a_cnt != H_ACTIVE*V_ACTIVE, set act_err.
    - locked <= 1 if no error occurred in this frame (frame_bad=0 and both checks pass), else 0.
  - Always on a frame close: v_seen <= 1, v_cnt <= 0, a_cnt <= 0, csum <= 0, frame_bad <= 0.
  - The first vsync fall after reset produces no frame_done.
- Simultaneous hsync fall and vsync fall on the same tick:
  - The frame closes with the pre-tick v_cnt.
  - That line counts as line 1 of the new frame (v_cnt <= 1).
  - A line-length error on this tick counts against the closing frame.
- Active pixel on the same tick as a vsync fall: the pixel belongs to the new frame (a_cnt <= 1, csum <= {10'b0, rgb}).
- Error flags are sticky until reset. locked is not sticky.
- Latency: outputs update 1 clock after the tick's rising clock edge.

Test Plan:
- Two ideal 640x480 frames (800 ticks/line, 525 lines, 640x480 active, colour 0), vga_clk = clock/4 -> frame_done pulses once, after the second vsync fall. Expected: frame_count=1, line_len=800, frame_lines=525, active_pixels=307200, checksum=0x0000, locked=1, all error flags 0.
- Ideal frames with colour 0x3F on only the first active pixel -> checksum=0x801F, locked=1.
- One line shortened to 799 ticks -> hlen_err=1; at that frame's close locked=0. The next clean frame gives locked=1 while hlen_err stays 1.
- Frame with 524 lines and 479 active lines -> vlen_err=1, act_err=1, frame_lines=524, active_pixels=306560.
- vga_clk held high for 10000 cycles mid-frame -> no output changes. Then assert reset for 1 cycle mid-frame -> all outputs 0; the first subsequent vsync fall gives no frame_done; the next full frame gives frame_count=1.
- hsync and vsync fall on the same tick -> frame_lines equals the lines before that tick; the following frame counts that line as line 1 (ideal timing gives frame_lines=525).
